// File: rtl/snake_target_gen.sv
// snake_target_gen: food-target generator for the snake game.
// A free-running Galois LFSR supplies candidate (H,V) grid coordinates.
// Out-of-range draws are discarded and redrawn instead of being folded, so
// every in-range cell is equally likely.
// Optional feature macro: TARGET_OCC_CHECK_EN. When defined, each in-range
// candidate goes through an occupancy query (QUERY/CHECK states) before it is
// committed. When undefined, the first in-range candidate is committed directly.
module snake_target_gen #(
  parameter int                H_BITS    = 8,
  parameter int                V_BITS    = 7,
  parameter int                H_MAX     = 160,
  parameter int                V_MAX     = 120,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
  parameter int                MAX_TRIES = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ,
  input  logic              OCC_HIT,
  output logic [H_BITS-1:0] CAND_H,
  output logic [V_BITS-1:0] CAND_V,
  output logic              CAND_VALID,
  output logic [H_BITS-1:0] TARGET_H,
  output logic [V_BITS-1:0] TARGET_V,
  output logic              TARGET_VALID,
  output logic              FORCED,
  output logic              BUSY
);

  // One extra bit on the limits so H_MAX == 2^H_BITS still compares correctly.
  localparam logic [H_BITS:0] H_LIMIT = (H_BITS+1)'(H_MAX);
  localparam logic [V_BITS:0] V_LIMIT = (V_BITS+1)'(V_MAX);

`ifdef TARGET_OCC_CHECK_EN
  localparam int              TRY_W    = $clog2(MAX_TRIES + 1);
  localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);
  localparam logic [TRY_W-1:0] TRY_SAT  = TRY_W'(MAX_TRIES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAW,
    ST_QUERY,
    ST_CHECK
  } state_t;

  logic [TRY_W-1:0] tries_reg;
  logic             last_try;
`else
  typedef enum logic {
    ST_IDLE,
    ST_DRAW
  } state_t;

  // Occupancy answer has no meaning without the query path.
  logic unused_occ_hit;
  assign unused_occ_hit = OCC_HIT;
`endif

  state_t            state_reg;
  logic [LFSR_W-1:0] lfsr_reg;
  logic [LFSR_W-1:0] lfsr_next;
  logic [H_BITS-1:0] raw_h;
  logic [V_BITS-1:0] raw_v;
  logic              in_range;

  // Next LFSR value and the raw candidate carved out of the current value.
  always_comb begin
    lfsr_next = {1'b0, lfsr_reg[LFSR_W-1:1]} ^ (lfsr_reg[0] ? LFSR_TAPS : '0);
    raw_h     = lfsr_reg[H_BITS-1:0];
    raw_v     = lfsr_reg[H_BITS+V_BITS-1:H_BITS];
    in_range  = ({1'b0, raw_h} < H_LIMIT) && ({1'b0, raw_v} < V_LIMIT);
  end

`ifdef TARGET_OCC_CHECK_EN
  // The current rejection would be the MAX_TRIES-th one.
  always_comb begin
    last_try = (tries_reg >= TRY_LAST);
  end

  // Request FSM with query handshake; all outputs are registered here.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      lfsr_reg     <= SEED;
      state_reg    <= ST_IDLE;
      tries_reg    <= '0;
      CAND_H       <= '0;
      CAND_V       <= '0;
      CAND_VALID   <= 1'b0;
      TARGET_H     <= '0;
      TARGET_V     <= '0;
      TARGET_VALID <= 1'b0;
      FORCED       <= 1'b0;
      BUSY         <= 1'b0;
    end else begin
      lfsr_reg     <= lfsr_next;
      CAND_VALID   <= 1'b0;
      TARGET_VALID <= 1'b0;
      FORCED       <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (REQ) begin
            state_reg <= ST_DRAW;
            tries_reg <= '0;
            BUSY      <= 1'b1;
          end
        end
        ST_DRAW: begin
          // Out-of-range values simply wait for the next LFSR step.
          if (in_range) begin
            CAND_H     <= raw_h;
            CAND_V     <= raw_v;
            CAND_VALID <= 1'b1;
            state_reg  <= ST_QUERY;
          end
        end
        ST_QUERY: begin
          state_reg <= ST_CHECK;
        end
        ST_CHECK: begin
          if (!OCC_HIT || last_try) begin
            TARGET_H     <= CAND_H;
            TARGET_V     <= CAND_V;
            TARGET_VALID <= 1'b1;
            FORCED       <= OCC_HIT;
            state_reg    <= ST_IDLE;
            BUSY         <= 1'b0;
          end else begin
            tries_reg <= (tries_reg == TRY_SAT) ? tries_reg : tries_reg + 1'b1;
            state_reg <= ST_DRAW;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          BUSY      <= 1'b0;
        end
      endcase
    end
  end
`else
  assign CAND_VALID = 1'b0;
  assign FORCED     = 1'b0;

  // Request FSM without occupancy check: first in-range draw is committed.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      lfsr_reg     <= SEED;
      state_reg    <= ST_IDLE;
      CAND_H       <= '0;
      CAND_V       <= '0;
      TARGET_H     <= '0;
      TARGET_V     <= '0;
      TARGET_VALID <= 1'b0;
      BUSY         <= 1'b0;
    end else begin
      lfsr_reg     <= lfsr_next;
      TARGET_VALID <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (REQ) begin
            state_reg <= ST_DRAW;
            BUSY      <= 1'b1;
          end
        end
        ST_DRAW: begin
          if (in_range) begin
            CAND_H       <= raw_h;
            CAND_V       <= raw_v;
            TARGET_H     <= raw_h;
            TARGET_V     <= raw_v;
            TARGET_VALID <= 1'b1;
            state_reg    <= ST_IDLE;
            BUSY         <= 1'b0;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          BUSY      <= 1'b0;
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_snake_target_gen.sv
// Directed bench for snake_target_gen with an LFSR reference model and a
// queue of predicted commits. Adapts to TARGET_OCC_CHECK_EN being defined or not.
module tb_snake_target_gen;

  localparam int          H_BITS    = 8;
  localparam int          V_BITS    = 7;
  localparam int          H_MAX     = 160;
  localparam int          V_MAX     = 120;
  localparam logic [15:0] TAPS      = 16'hB400;
  localparam logic [15:0] SEED      = 16'hACE1;
  localparam int          MAX_TRIES = 4;

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic              REQ = 1'b0;
  logic              OCC_HIT = 1'b0;
  logic [H_BITS-1:0] CAND_H;
  logic [V_BITS-1:0] CAND_V;
  logic              CAND_VALID;
  logic [H_BITS-1:0] TARGET_H;
  logic [V_BITS-1:0] TARGET_V;
  logic              TARGET_VALID;
  logic              FORCED;
  logic              BUSY;

  snake_target_gen #(
    .MAX_TRIES(MAX_TRIES)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .REQ(REQ),
    .OCC_HIT(OCC_HIT),
    .CAND_H(CAND_H),
    .CAND_V(CAND_V),
    .CAND_VALID(CAND_VALID),
    .TARGET_H(TARGET_H),
    .TARGET_V(TARGET_V),
    .TARGET_VALID(TARGET_VALID),
    .FORCED(FORCED),
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] h;
    logic [6:0] v;
    logic       forced;
    int         lat;
    int         queries;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic [15:0] m_lfsr;

  function automatic logic [15:0] step(input logic [15:0] l);
    return {1'b0, l[15:1]} ^ (l[0] ? TAPS : 16'h0000);
  endfunction

  function automatic bit in_rng(input logic [15:0] l);
    return (int'(l[7:0]) < H_MAX) && (int'(l[14:8]) < V_MAX);
  endfunction

  // Reference LFSR, free-running like the generator it predicts.
  always @(posedge CLK) begin
    if (RESET) m_lfsr <= SEED;
    else       m_lfsr <= step(m_lfsr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Predict the commit for a request sampled at the coming edge; the first
  // n_hits queries are answered as occupied.
  function automatic exp_t predict(input int n_hits);
    exp_t        e;
    logic [15:0] cur;
    int          lat;
    int          q;
    bit          done;
    cur  = step(m_lfsr);
    lat  = 0;
    q    = 0;
    done = 0;
    e.h = '0; e.v = '0; e.forced = 1'b0; e.lat = 0; e.queries = 0;
    while (!done) begin
      while (!in_rng(cur)) begin
        cur = step(cur);
        lat++;
      end
`ifdef TARGET_OCC_CHECK_EN
      if (q < n_hits && q + 1 < MAX_TRIES) begin
        cur = step(step(step(cur)));
        lat += 3;
        q++;
      end else begin
        e.h = cur[7:0]; e.v = cur[14:8];
        e.forced = (q < n_hits);
        e.lat = lat + 3;
        e.queries = q + 1;
        done = 1;
      end
`else
      e.h = cur[7:0]; e.v = cur[14:8];
      e.forced = 1'b0;
      e.lat = lat + 1;
      e.queries = n_hits * 0;
      done = 1;
`endif
    end
    return e;
  endfunction

  // Issue one request (REQ held for hold edges) and check the resulting commit.
  task automatic run_req(input string tag, input int n_hits, input int hold);
    exp_t e;
    int   cnt;
    int   qs;
    logic prev_cv;
    bit   got;
    sb.push_back(predict(n_hits));
    REQ = 1'b1;
    cnt = 0; qs = 0; prev_cv = 1'b0; got = 0;
    while (!got && cnt < 300) begin
      @(negedge CLK);
      cnt++;
      if (cnt >= hold) REQ = 1'b0;
`ifdef TARGET_OCC_CHECK_EN
      OCC_HIT = prev_cv ? ((qs - 1) < n_hits) : 1'b0;
`else
      OCC_HIT = 1'b1;
`endif
      if (CAND_VALID) qs++;
      prev_cv = CAND_VALID;
      if (TARGET_VALID) got = 1;
    end
    REQ = 1'b0;
    OCC_HIT = 1'b0;
    chk({tag, "_commit_seen"}, 32'(got), 32'd1);
    e = sb.pop_front();
    if (got) begin
      chk({tag, "_target_h"}, 32'(TARGET_H), 32'(e.h));
      chk({tag, "_target_v"}, 32'(TARGET_V), 32'(e.v));
      chk({tag, "_cand_h"}, 32'(CAND_H), 32'(e.h));
      chk({tag, "_cand_v"}, 32'(CAND_V), 32'(e.v));
      chk({tag, "_forced"}, 32'(FORCED), 32'(e.forced));
      chk({tag, "_latency"}, 32'(cnt - 1), 32'(e.lat));
      chk({tag, "_queries"}, 32'(qs), 32'(e.queries));
      chk({tag, "_in_range"}, 32'((int'(TARGET_H) < H_MAX) && (int'(TARGET_V) < V_MAX)), 32'd1);
      chk({tag, "_busy_after"}, 32'(BUSY), 32'd0);
    end
    $display("txn %s h=%0d v=%0d lat=%0d queries=%0d forced=%0b", tag, TARGET_H, TARGET_V, cnt - 1, qs, FORCED);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_target_h"}, 32'(TARGET_H), 32'd0);
    chk({tag, "_target_v"}, 32'(TARGET_V), 32'd0);
    chk({tag, "_cand_h"}, 32'(CAND_H), 32'd0);
    chk({tag, "_cand_v"}, 32'(CAND_V), 32'd0);
    chk({tag, "_cand_valid"}, 32'(CAND_VALID), 32'd0);
    chk({tag, "_target_valid"}, 32'(TARGET_VALID), 32'd0);
    chk({tag, "_forced"}, 32'(FORCED), 32'd0);
    chk({tag, "_busy"}, 32'(BUSY), 32'd0);
  endtask

  initial begin
    int  extra;
    int  tv_seen;
    bit  seen;

    // Reset held three cycles.
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    check_outputs_zero("reset");
    RESET = 1'b0;
    @(negedge CLK);

    // First request from the seeded state.
    run_req("first", 0, 1);

    // Free requests with random idle gaps.
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge CLK);
      run_req("free", 0, 1);
    end

    // Two occupied answers, then a free cell.
    run_req("occ2", 2, 1);
    // Every answer occupied: commit forced after MAX_TRIES queries.
    run_req("forced", MAX_TRIES, 1);
    run_req("after_forced", 0, 1);

    // REQ still high on the edge after acceptance: only one commit expected.
    run_req("busy_req", 0, 2);
    tv_seen = 0;
    repeat (10) begin
      @(negedge CLK);
      if (TARGET_VALID) tv_seen++;
    end
    chk("busy_req_no_extra_commit", 32'(tv_seen), 32'd0);

    // Reset while a request is in flight.
    REQ = 1'b1;
    @(negedge CLK);
    REQ = 1'b0;
`ifdef TARGET_OCC_CHECK_EN
    seen = 0;
    extra = 0;
    while (!seen && extra < 100) begin
      if (CAND_VALID) seen = 1;
      else begin
        @(negedge CLK);
        extra++;
      end
    end
    chk("midreset_query_reached", 32'(seen), 32'd1);
`else
    seen = 1;
    extra = 0;
`endif
    RESET = 1'b1;
    tv_seen = 0;
    repeat (2) begin
      @(negedge CLK);
      if (TARGET_VALID) tv_seen++;
    end
    check_outputs_zero("midreset");
    RESET = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      if (TARGET_VALID) tv_seen++;
    end
    chk("midreset_no_commit", 32'(tv_seen), 32'd0);
    chk("midreset_idle", 32'(BUSY), 32'd0);

    // Generator and model must still agree after the abort.
    run_req("post_reset", 0, 1);
    run_req("post_reset_occ", 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/snake_target_gen.md
# snake_target_gen

Parametrised food-target generator for the snake game. A free-running Galois LFSR supplies candidate grid coordinates. Out-of-range draws are rejected and redrawn instead of being reduced modulo the grid size, so the distribution is unbiased. Each in-range candidate can be checked against the snake body through an occupancy query handshake. The block sits between the master state machine (which requests targets) and the snake body store / VGA renderer (which consume `TARGET_H`/`TARGET_V`).

## Interface
- `H_BITS`, 8, width of the horizontal coordinate.
- `V_BITS`, 7, width of the vertical coordinate.
- `H_MAX`, 160, number of columns; valid H is 0..H_MAX-1. Requires H_MAX ≤ 2^H_BITS.
- `V_MAX`, 120, number of rows; valid V is 0..V_MAX-1. Requires V_MAX ≤ 2^V_BITS.
- `LFSR_W`, 16, LFSR width. Requires H_BITS+V_BITS ≤ LFSR_W.
- `LFSR_TAPS`, 16'hB400, Galois feedback mask (maximal-length for 16 bits).
- `SEED`, 16'hACE1, LFSR reset value. Must be nonzero.
- `MAX_TRIES`, 8, occupied-candidate rejections allowed before a forced accept. Must be ≥ 1.

Ports:
- `CLK` in 1: clock. All logic on posedge.
- `RESET` in 1: reset, synchronous, active-high.
- `REQ` in 1: request a new target. Sampled only in IDLE.
- `OCC_HIT` in 1: occupancy answer. Sampled in CHECK; 1 means the candidate lies on the snake.
- `CAND_H` out H_BITS: candidate column for the occupancy query.
- `CAND_V` out V_BITS: candidate row for the occupancy query.
- `CAND_VALID` out 1: one-cycle query strobe.
- `TARGET_H` out H_BITS: committed target column. Held between commits.
- `TARGET_V` out V_BITS: committed target row. Held between commits.
- `TARGET_VALID` out 1: one-cycle pulse on each commit.
- `FORCED` out 1: one-cycle pulse, coincident with `TARGET_VALID`, when the commit was forced by exhausting MAX_TRIES.
- `BUSY` out 1: high whenever the state is not IDLE.

## Operation
- The LFSR advances every cycle regardless of state. Galois step: `lfsr <= {1'b0, lfsr[W-1:1]} ^ (lfsr[0] ? LFSR_TAPS : 0)`.
- Raw candidate bits: H = `lfsr[H_BITS-1:0]`, V = `lfsr[H_BITS+V_BITS-1:H_BITS]`. The in-range test is H < H_MAX && V < V_MAX.
- FSM states: IDLE, DRAW, QUERY, CHECK.
  - IDLE: if REQ is high, go to DRAW and clear the try counter. Otherwise stay in IDLE.
  - DRAW: if the current candidate is in range, latch it into `CAND_H`/`CAND_V` and go to QUERY. Otherwise stay in DRAW and evaluate the next LFSR value. Out-of-range redraws do not increment the try counter.
  - QUERY: `CAND_VALID` is high for exactly this cycle. Always go to CHECK.
  - CHECK: evaluate `OCC_HIT` and the try counter as follows.
    - `OCC_HIT`=0: commit `CAND` to `TARGET`, pulse `TARGET_VALID`, go to IDLE.
    - `OCC_HIT`=1 and tries+1 < MAX_TRIES: increment tries, go to DRAW.
    - `OCC_HIT`=1 and tries+1 == MAX_TRIES: commit anyway, pulse `TARGET_VALID` and `FORCED`, go to IDLE.
- The try counter is $clog2(MAX_TRIES+1) bits wide and saturates.
- REQ while BUSY is ignored. Requests are not queued.
- REQ held high across a commit starts a new draw on the cycle after return to IDLE.
- A maximal-length LFSR guarantees that DRAW terminates.

## Timing
- Reset values:
  - LFSR = SEED; FSM in IDLE; tries = 0.
  - `TARGET_H` = 0, `TARGET_V` = 0, `CAND_H` = 0, `CAND_V` = 0.
  - `CAND_VALID`, `TARGET_VALID`, `FORCED`, `BUSY` = 0.
- RESET asserted mid-operation aborts at the next edge. No `TARGET_VALID` is produced and `TARGET_*` return to 0.
- All outputs are registered.
- Minimum latency, REQ sampled at edge k:
  - DRAW during k..k+1.
  - QUERY during k+1..k+2, `CAND_VALID` high.
  - CHECK during k+2..k+3; `OCC_HIT` must be valid before edge k+3.
  - `TARGET_*`/`TARGET_VALID` update after edge k+3. Minimum latency is 3 cycles.
- Each out-of-range redraw adds 1 cycle. Each occupied rejection adds 3 cycles.
- The occupancy responder must return `OCC_HIT` exactly one cycle after `CAND_VALID`.

## Configuration
- `TARGET_OCC_CHECK_EN` defined: the full FSM as above.
- `TARGET_OCC_CHECK_EN` undefined:
  - QUERY and CHECK are not compiled.
  - `OCC_HIT` is ignored; `CAND_VALID` and `FORCED` are tied to 0.
  - DRAW commits the first in-range candidate directly. Minimum latency is 1 cycle, and `CAND_*` track each commit.

## Test plan
- Reset: hold RESET 3 cycles → all outputs 0, BUSY=0. The first REQ yields a target matching the bench LFSR model seeded 16'hACE1.
- Unbiased range: 160×120, `OCC_HIT`=0, 10000 REQs → every `TARGET_H` < 160 and `TARGET_V` < 120. Each sequence matches the model's first in-range candidate.
- No rejection: H_MAX=256, V_MAX=128 → every commit occurs exactly 3 cycles after REQ, and `CAND_VALID` pulses once per request.
- Occupied: responder flags the first two candidates → 2 extra draws; the third candidate is committed, `FORCED`=0, latency ≥ 9 cycles.
- Forced: `OCC_HIT` tied to 1, MAX_TRIES=4 → 4 `CAND_VALID` pulses, then `TARGET_VALID` and `FORCED` high in the same cycle, target equal to the 4th candidate.
- Abuse: REQ re-pulsed while BUSY → exactly one commit. RESET asserted in QUERY → no `TARGET_VALID`, outputs 0, FSM in IDLE. With the macro undefined, commit occurs 1 cycle after REQ.
